step_clock_controller: RTL and testbench
========================================

# step_clock_controller

Upstream pacing stage for the FPGA-mapped pipelined processor. It turns the board push-button and run switch into a one-cycle processor advance enable, `proc_tick`, that replaces the free-running clock feed into the processor. It supports three modes: manual single-step, free-run at a divided rate, and a terminal halt when the processor raises its instruction stop signal. It also keeps a 16-bit count of issued ticks for the seven-segment debug display.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a button level change; min 2.
- `RUN_DIVIDE`, default 25_000_000: clock cycles per tick in run mode; min 2.

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  board clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `step_button_n`  in  1  raw push-button, active-low, asynchronous to `clock`.
- `run_mode`  in  1  switch: 1 = free-run, 0 = single-step; treated as quasi-static, so no synchronizer.
- `instr_stop`  in  1  processor stop signal; synchronous to `clock`.
- `proc_tick`  out  1  one-cycle advance enable to the processor.
- `tick_count`  out  16  number of ticks issued since reset.
- `ctrl_state`  out  2  current FSM state encoding.
- `halted`  out  1  high when `ctrl_state` is S_HALT.
- `button_level`  out  1  debounced button, 1 = pressed.

## Operation
- Button path:
  - 2-flop synchronizer on `~step_button_n`.
  - Debouncer: counter increments while the synchronized level differs from `button_level`, and clears to 0 when they are equal.
  - When the counter would reach `DEBOUNCE_CYCLES`, `button_level` flips and the counter clears.
  - `press_pulse` is a registered rising edge of `button_level`.
- FSM states: S_STEP=2'b00, S_RUN=2'b01, S_HALT=2'b10. Encoding 2'b11 is unreachable and decodes to S_HALT.
- Transitions, with priority top to bottom:
  - `instr_stop`=1 in S_STEP or S_RUN → S_HALT.
  - S_STEP with `run_mode`=1 → S_RUN.
  - S_RUN with `run_mode`=0 → S_STEP.
  - S_HALT exits only via `reset`.
- S_STEP: each `press_pulse` produces exactly one `proc_tick` on the next cycle. Holding the button gives one tick only.
- S_RUN:
  - Rate counter runs 0..RUN_DIVIDE-1 and is cleared on entry to S_RUN.
  - `proc_tick`=1 in the cycle after the counter equals RUN_DIVIDE-1; the counter then wraps to 0.
  - Button presses are ignored.
- S_HALT: `proc_tick` is held 0. The debouncer keeps running, so `button_level` stays live.
- `tick_count` increments by 1 on every cycle in which `proc_tick`=1 and wraps FFFF→0000.

## Timing
- Reset values: `proc_tick`=0, `tick_count`=0, `ctrl_state`=S_STEP, `halted`=0, `button_level`=0. Synchronizer, debounce counter, rate counter and `press_pulse` all clear to 0.
- Step latency: a button held pressed from edge E (first edge sampling it low) gives `proc_tick` high for one cycle after edge E+DEBOUNCE_CYCLES+3.
- Bounce: any release shorter than `DEBOUNCE_CYCLES` cycles restarts the count. No tick and no `button_level` change result.
- Run period: ticks are exactly `RUN_DIVIDE` cycles apart. The first tick falls `RUN_DIVIDE` cycles after the edge that enters S_RUN.
- `instr_stop` and a pending tick in the same cycle: the halt wins and `proc_tick` is 0 from that edge onward. A tick already high in the current cycle completes.
- Mode change: the S_RUN→S_STEP edge drops any in-progress rate count. A `press_pulse` arriving on the same edge as S_STEP→S_RUN is discarded.
- Reset mid-debounce or mid-run: all progress is lost. A button still held after reset needs a full debounce period before `button_level`=1.

## Structure
- Package `step_ctrl_pkg`: state encodings S_STEP/S_RUN/S_HALT, and the state width localparam (2).
- Sub-module `button_debouncer`, parameterized by `DEBOUNCE_CYCLES`. It contains the synchronizer, debounce counter, `button_level` and `press_pulse`.
- Top module contains the FSM, rate counter and `tick_count`.
- Counter widths are `$clog2` of the parameters.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and RUN_DIVIDE=5.
- Reset, then hold `step_button_n`=0 from edge 10 → exactly one `proc_tick` after edge 17; `tick_count`=1; no further ticks while held.
- Button glitches of 0,1,0,1 (1-cycle each), then steady release → `button_level` never 1; `tick_count` stays 0.
- `run_mode`=1 at edge 20 for 23 cycles → ticks after edges 25, 30, 35, 40; `tick_count`=4. `run_mode`=0 at edge 43 → no more ticks.
- S_RUN with `instr_stop`=1 on the edge where the rate counter equals 4 → no tick; `halted`=1; `ctrl_state`=2'b10. A later button press and `run_mode` toggle give no ticks.
- Preload via 65535 run ticks, then one more → `tick_count` wraps to 0000.
- `reset` pulse while in S_HALT with the button held → `ctrl_state`=00, `tick_count`=0, `button_level`=0; `button_level` rises 6 edges after reset deasserts.

Source files
------------

// File: rtl/step_ctrl_pkg.sv
// Shared definitions for the step clock controller: FSM state encoding,
// state/counter widths and the state-code decode used for the halted flag.
package step_ctrl_pkg;

  localparam int STATE_W      = 2;
  localparam int TICK_COUNT_W = 16;

  typedef enum logic [STATE_W-1:0] {
    S_STEP = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } ctrl_state_e;

  // Both S_HALT and the unused code 2'b11 mean "halted", so only the MSB matters.
  function automatic logic is_halt_code(input logic [STATE_W-1:0] code);
    return code[STATE_W-1];
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Push-button front end: two-flop synchronizer, stability counter that
// accepts a level change only after DEBOUNCE_CYCLES consecutive disagreeing
// samples, and a registered rising-edge pulse of the accepted level.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic button_n_i,
  output logic level_o,
  output logic press_o
);

  localparam int            CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;
  logic             prev_q;
  logic             press_q;

  // Bring the active-low asynchronous button into the clock domain as "pressed".
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= ~button_n_i;
      sync2_q <= sync1_q;
    end
  end

  // Count disagreeing samples; any agreeing sample restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Hold the accepted level and its stability counter.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  // One-cycle pulse on each accepted press (rising edge of the level).
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      prev_q  <= level_q;
      press_q <= level_q & ~prev_q;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/step_clock_controller.sv
// Processor pacing stage: turns the debounced step button and the run switch
// into a one-cycle proc_tick, with a terminal halt on instr_stop and a
// wrapping 16-bit count of issued ticks for the debug display.
module step_clock_controller
  import step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int RUN_DIVIDE      = 25_000_000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    step_button_n,
  input  logic                    run_mode,
  input  logic                    instr_stop,
  output logic                    proc_tick,
  output logic [TICK_COUNT_W-1:0] tick_count,
  output logic [STATE_W-1:0]      ctrl_state,
  output logic                    halted,
  output logic                    button_level
);

  localparam int               RATE_W    = $clog2(RUN_DIVIDE);
  localparam logic [RATE_W-1:0] RATE_LAST = RATE_W'(RUN_DIVIDE - 1);

  ctrl_state_e             state_q;
  logic [RATE_W-1:0]       rate_q;
  logic                    tick_q;
  logic [TICK_COUNT_W-1:0] tick_count_q;
  logic [TICK_COUNT_W-1:0] tick_count_d;
  logic                    press_pulse;
  logic                    level;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock_i   (clock),
    .reset_i   (reset),
    .button_n_i(step_button_n),
    .level_o   (level),
    .press_o   (press_pulse)
  );

  // Mode FSM with the run-rate counter and the registered tick. Halt has top
  // priority so a tick due on the stop edge is suppressed; the rate counter
  // defaults to zero so it restarts on every entry into S_RUN.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_STEP;
      rate_q  <= '0;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      rate_q <= '0;
      case (state_q)
        S_STEP: begin
          if (instr_stop) begin
            state_q <= S_HALT;
          end else if (run_mode) begin
            state_q <= S_RUN;
          end else begin
            tick_q <= press_pulse;
          end
        end
        S_RUN: begin
          if (instr_stop) begin
            state_q <= S_HALT;
          end else if (!run_mode) begin
            state_q <= S_STEP;
          end else if (rate_q == RATE_LAST) begin
            tick_q <= 1'b1;
          end else begin
            rate_q <= rate_q + 1'b1;
          end
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_HALT;
        end
      endcase
    end
  end

  assign tick_count_d = tick_count_q + {{(TICK_COUNT_W-1){1'b0}}, tick_q};

  // Count every cycle in which the processor was advanced; wraps naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      tick_count_q <= '0;
    end else begin
      tick_count_q <= tick_count_d;
    end
  end

  assign proc_tick    = tick_q;
  assign tick_count   = tick_count_q;
  assign ctrl_state   = state_q;
  assign halted       = is_halt_code(state_q);
  assign button_level = level;

endmodule

// File: tb/tb_step_clock_controller.sv
// Bench for step_clock_controller with DEBOUNCE_CYCLES=4, RUN_DIVIDE=5.
// Expected outputs come from an edge-indexed reference model: the debounced
// level is derived from a window over the history of delayed button samples,
// run ticks from the distance to the S_RUN entry edge.
module tb_step_clock_controller;

  localparam int DB   = 4;
  localparam int RD   = 5;
  localparam int MAXC = 4096;

  logic        clock = 1'b0;
  logic        reset;
  logic        step_button_n;
  logic        run_mode;
  logic        instr_stop;
  logic        proc_tick;
  logic [15:0] tick_count;
  logic [1:0]  ctrl_state;
  logic        halted;
  logic        button_level;

  int n_checks = 0;
  int n_fail   = 0;

  step_clock_controller #(
    .DEBOUNCE_CYCLES(DB),
    .RUN_DIVIDE     (RD)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .step_button_n(step_button_n),
    .run_mode     (run_mode),
    .instr_stop   (instr_stop),
    .proc_tick    (proc_tick),
    .tick_count   (tick_count),
    .ctrl_state   (ctrl_state),
    .halted       (halted),
    .button_level (button_level)
  );

  always #5 clock = ~clock;

  // Reference model state, indexed by edge number n.
  bit          ps [MAXC];   // pressed as sampled at edge n
  bit          dh [MAXC];   // synchronized (delayed) pressed after edge n
  bit          lv [MAXC];   // debounced level after edge n
  int          n         = 0;
  int          last_clr  = 0;
  int          m_state   = 0;  // 0 step, 1 run, 2 halt
  int          run_entry = 0;
  bit          m_tick    = 1'b0;
  bit          m_press   = 1'b0;
  logic [15:0] m_count   = '0;

  task automatic model_edge(input bit r, input bit p, input bit rm, input bit st);
    bit new_tick;
    bit flip;
    n++;
    if (n >= MAXC) begin
      $display("FAIL model_capacity edge=%0d limit=%0d", n, MAXC);
      $fatal(1, "model history exhausted");
    end
    if (r) begin
      ps[n] = 1'b0; dh[n] = 1'b0; lv[n] = 1'b0;
      last_clr = n; m_press = 1'b0; m_state = 0; m_tick = 1'b0; m_count = '0;
      return;
    end
    m_count  = m_count + {15'd0, m_tick};
    new_tick = 1'b0;
    case (m_state)
      0: if (st) m_state = 2;
         else if (rm) begin m_state = 1; run_entry = n; end
         else new_tick = m_press;
      1: if (st) m_state = 2;
         else if (!rm) m_state = 0;
         else new_tick = ((n - run_entry) % RD == 0);
      default: ;
    endcase
    m_tick  = new_tick;
    m_press = (n >= 2) && lv[n-1] && !lv[n-2];
    ps[n] = p;
    dh[n] = ps[n-1];
    // Level flips once DB consecutive delayed samples since the last clear disagree with it.
    flip = (n - DB >= last_clr);
    if (flip) begin
      for (int k = n - DB; k <= n - 1; k++) begin
        if (dh[k] == lv[n-1]) flip = 1'b0;
      end
    end
    lv[n] = flip ? ~lv[n-1] : lv[n-1];
    if (flip) last_clr = n;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("proc_tick",    {15'd0, proc_tick},    {15'd0, m_tick});
    chk("tick_count",   tick_count,            m_count);
    chk("ctrl_state",   {14'd0, ctrl_state},   16'(m_state));
    chk("halted",       {15'd0, halted},       {15'd0, (m_state == 2)});
    chk("button_level", {15'd0, button_level}, {15'd0, lv[n]});
  endtask

  task automatic step(input bit r, input bit btn_n, input bit rm, input bit st);
    reset = r; step_button_n = btn_n; run_mode = rm; instr_stop = st;
    @(posedge clock);
    model_edge(r, ~btn_n, rm, st);
    #1;
    check_all();
  endtask

  initial begin
    logic [15:0] base;
    int          run_len;
    bit          b_n;
    bit          rm;
    bit          r;
    bit          st;

    // Reset state
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("reset_state", {14'd0, ctrl_state}, 16'd0);
    chk("reset_count", tick_count, 16'd0);

    // Single step: held button gives exactly one tick, 7 edges after first low sample
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("step_latency", {15'd0, proc_tick}, {15'd0, (i == 7)});
    end
    chk("step_count", tick_count, 16'd1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0);

    // Glitches and a short press: no level change, no tick
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("glitch_level", {15'd0, button_level}, 16'd0);
    chk("glitch_count", tick_count, 16'd1);

    // Run mode: ticks every RD cycles from the entry edge, stop on switch-off
    base = tick_count;
    for (int i = 0; i < 23; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk("run_period", {15'd0, proc_tick}, {15'd0, (i > 0 && i % RD == 0)});
    end
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("run_count", tick_count, base + 16'd4);

    // Halt on the edge where a run tick was due
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("halt_tick",  {15'd0, proc_tick}, 16'd0);
    chk("halt_flag",  {15'd0, halted},    16'd1);
    chk("halt_state", {14'd0, ctrl_state}, 16'd2);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b0, i[1], 1'b0);
    chk("halt_count", tick_count, 16'd0);
    chk("halt_level_live", {15'd0, button_level}, 16'd1);

    // Reset while halted with the button held: full debounce needed again
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_state", {14'd0, ctrl_state}, 16'd0);
    chk("rst_level", {15'd0, button_level}, 16'd0);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 5) chk("rst_level_5", {15'd0, button_level}, 16'd0);
      if (i == 6) chk("rst_level_6", {15'd0, button_level}, 16'd1);
    end
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0);

    // Counter wrap: preload near the top, then run past FFFF
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    m_count = 16'hFFFC;
    force dut.tick_count_q = 16'hFFFC;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    release dut.tick_count_q;
    for (int i = 0; i < 26; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("wrap_count", tick_count, 16'h0001);

    // Randomized mix of presses, bounces, mode changes, stops and resets
    step(1'b1, 1'b1, 1'b0, 1'b0);
    run_len = 0; b_n = 1'b1; rm = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (run_len == 0) begin
        b_n = ~b_n;
        run_len = $urandom_range(1, 12);
      end
      run_len--;
      if ($urandom_range(0, 39) == 0) rm = ~rm;
      st = ($urandom_range(0, 149) == 0);
      r  = ($urandom_range(0, 199) == 0) || (m_state == 2 && $urandom_range(0, 24) == 0);
      step(r, b_n, rm, st);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
